// File: rtl/rr_grant_arbiter_pkg.sv
// Shared types and sizing constants for the round-robin grant arbiter.
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/rr_grant_arbiter_if.sv
// Request/grant bundle between the requesters and the arbiter.
interface rr_grant_arbiter_if;
  import arb_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_valid;
  logic               gnt_new;

  // Requester side drives req and observes the grant.
  modport master (
    output req,
    input  gnt,
    input  gnt_idx,
    input  gnt_valid,
    input  gnt_new
  );

  // Arbiter side samples req and drives the grant.
  modport slave (
    input  req,
    output gnt,
    output gnt_idx,
    output gnt_valid,
    output gnt_new
  );
endinterface

// File: rtl/rr_pick4.sv
// Combinational rotating-priority picker: first set request at or above
// start (mod 4), returned as one-hot, binary index and a found flag.
module rr_pick4
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   start,
  output logic [NUM_REQ-1:0] win,
  output logic [IDX_W-1:0]   win_idx,
  output logic               found
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [NUM_REQ-1:0]   rot_oh;
  logic                 hit;

  // Rotate so start sits at bit 0, take the lowest set bit, rotate back, encode.
  always_comb begin
    dbl     = {req, req};
    rot     = dbl[start +: NUM_REQ];
    rot_oh  = '0;
    hit     = 1'b0;
    win     = '0;
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rot[i] && !hit) begin
        rot_oh[i] = 1'b1;
        hit       = 1'b1;
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      win[j] = rot_oh[IDX_W'(j) - start];
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (win[j]) win_idx = IDX_W'(j);
    end
    found = |req;
  end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter for four requesters with bounded, restartable tenure.
// The search always begins one past the last owner, so a timed-out owner
// becomes lowest priority and idle-state arbitration resumes the rotation.
module rr_grant_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  rr_grant_arbiter_if.slave   bus
);

  state_t              state;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [IDX_W-1:0]    last_owner;
  logic [IDX_W-1:0]    start;
  logic [NUM_REQ-1:0]  win;
  logic [IDX_W-1:0]    win_idx;
  logic                found;
  logic                keep;

  rr_pick4 u_pick (
    .req     (bus.req),
    .start   (start),
    .win     (win),
    .win_idx (win_idx),
    .found   (found)
  );

  // Search origin and the decision to extend the current tenure.
  always_comb begin
    start = last_owner + IDX_W'(1);
    keep  = bus.req[last_owner] &&
            ((MAX_HOLD == 0) || (hold_cnt < HOLD_W'(MAX_HOLD)));
  end

  // Grant FSM: IDLE waits for any request; BUSY holds, hands over or releases.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bus.gnt       <= '0;
      bus.gnt_idx   <= '0;
      bus.gnt_valid <= 1'b0;
      bus.gnt_new   <= 1'b0;
      hold_cnt      <= '0;
      last_owner    <= IDX_W'(NUM_REQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state         <= BUSY;
            bus.gnt       <= win;
            bus.gnt_idx   <= win_idx;
            bus.gnt_valid <= 1'b1;
            bus.gnt_new   <= 1'b1;
            hold_cnt      <= HOLD_W'(1);
            last_owner    <= win_idx;
          end else begin
            bus.gnt_new   <= 1'b0;
          end
        end
        BUSY: begin
          if (keep) begin
            bus.gnt_new <= 1'b0;
            if (hold_cnt != '1) hold_cnt <= hold_cnt + HOLD_W'(1);
          end else if (found) begin
            // Release with another requester waiting, or timeout (the
            // owner is searched last and may win its own re-grant).
            bus.gnt       <= win;
            bus.gnt_idx   <= win_idx;
            bus.gnt_valid <= 1'b1;
            bus.gnt_new   <= 1'b1;
            hold_cnt      <= HOLD_W'(1);
            last_owner    <= win_idx;
          end else begin
            // gnt_idx keeps the last owner's index while idle.
            state         <= IDLE;
            bus.gnt       <= '0;
            bus.gnt_valid <= 1'b0;
            bus.gnt_new   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench for rr_grant_arbiter: one instance with MAX_HOLD=8 and one
// with MAX_HOLD=4, sharing clock and reset.
module tb_rr_grant_arbiter;
  import arb_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  rr_grant_arbiter_if if8 ();
  rr_grant_arbiter_if if4 ();

  rr_grant_arbiter #(.MAX_HOLD(8), .HOLD_W(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (if8.slave)
  );

  rr_grant_arbiter #(.MAX_HOLD(4), .HOLD_W(8)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (if4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check8(input string tag, input logic [3:0] g, input logic [1:0] idx,
                        input logic v, input logic n);
    check({tag, ".gnt"},   {4'b0, if8.gnt},       {4'b0, g});
    check({tag, ".idx"},   {6'b0, if8.gnt_idx},   {6'b0, idx});
    check({tag, ".valid"}, {7'b0, if8.gnt_valid}, {7'b0, v});
    check({tag, ".new"},   {7'b0, if8.gnt_new},   {7'b0, n});
  endtask

  task automatic check4(input string tag, input logic [3:0] g, input logic [1:0] idx,
                        input logic v, input logic n);
    check({tag, ".gnt"},   {4'b0, if4.gnt},       {4'b0, g});
    check({tag, ".idx"},   {6'b0, if4.gnt_idx},   {6'b0, idx});
    check({tag, ".valid"}, {7'b0, if4.gnt_valid}, {7'b0, v});
    check({tag, ".new"},   {7'b0, if4.gnt_new},   {7'b0, n});
  endtask

  initial begin
    logic [3:0] exp_g;
    logic [1:0] exp_i;
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    if8.req = 4'b0000;
    if4.req = 4'b0000;
    step();
    step();
    check8("reset8", 4'b0000, 2'd0, 1'b0, 1'b0);
    check4("reset4", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Priority starts at 0 after reset: 1010 grants bit 1 one edge later.
    rst     = 1'b0;
    if8.req = 4'b1010;
    step();
    check8("first_grant", 4'b0010, 2'd1, 1'b1, 1'b1);
    step();
    check8("hold1", 4'b0010, 2'd1, 1'b1, 1'b0);

    // Owner 1 releases while 3 waits: same-edge handover, no gap.
    if8.req = 4'b1000;
    step();
    check8("handover", 4'b1000, 2'd3, 1'b1, 1'b1);

    // Get requester 1 to own, then reset mid-tenure with 0110 pending.
    if8.req = 4'b0010;
    step();
    check8("own1", 4'b0010, 2'd1, 1'b1, 1'b1);
    if8.req = 4'b0110;
    rst     = 1'b1;
    step();
    check8("mid_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    check8("post_rst", 4'b0010, 2'd1, 1'b1, 1'b1);

    // Owner 1 drops: search from 2 finds 2.
    if8.req = 4'b0100;
    step();
    check8("own2", 4'b0100, 2'd2, 1'b1, 1'b1);

    // Owner 2 releases with no requests: idle, index kept at 2.
    if8.req = 4'b0000;
    step();
    check8("idle_after2", 4'b0000, 2'd2, 1'b0, 1'b0);
    step();
    check8("idle_stay", 4'b0000, 2'd2, 1'b0, 1'b0);

    // Search starts at 3 and wraps: 0101 grants bit 0.
    if8.req = 4'b0101;
    step();
    check8("wrap_grant0", 4'b0001, 2'd0, 1'b1, 1'b1);

    // A short pulse on req[1] during owner 0's tenure is not remembered.
    if8.req = 4'b0011;
    step();
    check8("pulse_hold", 4'b0001, 2'd0, 1'b1, 1'b0);
    if8.req = 4'b0001;
    step();
    check8("pulse_gone", 4'b0001, 2'd0, 1'b1, 1'b0);
    if8.req = 4'b0000;
    step();
    check8("no_latch", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Reset, then saturate both instances: 1111 on dut8, only req[2] on dut4.
    rst = 1'b1;
    step();
    rst     = 1'b0;
    if8.req = 4'b1111;
    if4.req = 4'b0100;
    for (int k = 0; k < 40; k++) begin
      step();
      exp_i = 2'((k / 8) % 4);
      exp_g = 4'b0001 << exp_i;
      check8("rotate8", exp_g, exp_i, 1'b1, (k % 8) == 0);
      check4("solo4", 4'b0100, 2'd2, 1'b1, (k % 4) == 0);
    end

    // Drop everything: both go idle and keep their last index.
    if8.req = 4'b0000;
    if4.req = 4'b0000;
    step();
    check8("final_idle8", 4'b0000, 2'd0, 1'b0, 1'b0);
    check4("final_idle4", 4'b0000, 2'd2, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
